// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle between the board header (master side) and the burst memory slave.
interface spi_memory_burst_if;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;

    modport master (output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_oe, leds);
    modport slave  (input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_oe, leds);
endinterface

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory with parametrised address/data widths and
// auto-incrementing, wrapping burst reads and writes. All pins are synchronised
// into clk; edges of the synced SCLK drive the frame FSM.
module spi_memory_burst #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_memory_burst_if.slave  spi
);
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RW, S_WRITE, S_READ} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d;
    logic                   rise, fall;
    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_WIDTH-1:0]  addr, addr_shift, addr_inc;
    logic [DATA_WIDTH-1:0]  rx, tx, data_shift;
    logic                   armed;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchroniser chains. CS resets to "selected" so a CS held low across reset
    // cannot arm the FSM until it is really seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi_pin};
            // Tracks the synced SCLK every cycle, including while CS is high,
            // so the CS falling edge never looks like an SCLK edge.
            sclk_d    <= sclk_s;
        end
    end

    // Edge strobes and next-value helpers for the shift registers.
    always_comb begin
        rise       = sclk_s & ~sclk_d;
        fall       = ~sclk_s & sclk_d;
        addr_shift = ADDR_WIDTH'({addr, mosi_s});
        data_shift = DATA_WIDTH'({rx, mosi_s});
        addr_inc   = addr + ADDR_WIDTH'(1);
        mem_we     = !reset && (state == S_WRITE) && rise && (bit_cnt == DATA_LAST);
    end

    // Memory array: not reset, written on the rising edge of a word's last bit.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= data_shift;
    end

    // Frame FSM with registered MISO, output enable and LEDs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            addr         <= '0;
            rx           <= '0;
            tx           <= '0;
            armed        <= 1'b0;
            spi.miso_pin <= 1'b0;
            spi.miso_oe  <= 1'b0;
            spi.leds     <= 4'h0;
        end else begin
            if (cs_s) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    spi.miso_oe  <= 1'b0;
                    spi.miso_pin <= 1'b0;
                    if (!cs_s && armed) begin
                        bit_cnt <= '0;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: if (rise) begin
                    addr <= addr_shift;
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt <= '0;
                        state   <= S_RW;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_RW: if (rise) begin
                    bit_cnt <= '0;
                    if (mosi_s) begin
                        tx          <= mem[addr];
                        spi.miso_oe <= 1'b1;
                        state       <= S_READ;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: if (rise) begin
                    rx <= data_shift;
                    if (bit_cnt == DATA_LAST) begin
                        spi.leds <= 4'({4'h0, data_shift});
                        addr     <= addr_inc;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_READ: begin
                    spi.miso_oe <= 1'b1;
                    if (fall) begin
                        spi.miso_pin <= tx[DATA_WIDTH-1];
                        if (bit_cnt == DATA_LAST) begin
                            // Prefetch the next word so its MSB follows with no gap.
                            bit_cnt <= '0;
                            addr    <= addr_inc;
                            tx      <= mem[addr_inc];
                        end else begin
                            tx      <= tx << 1;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // CS high ends the frame; overrides the state update above, after any
            // word completed on this same cycle has been committed.
            if (cs_s && state != S_IDLE) begin
                state        <= S_IDLE;
                spi.miso_oe  <= 1'b0;
                spi.miso_pin <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: two instances (default widths and a
// 4-bit address / 16-bit data / 3-stage variant) share SCLK/MOSI with separate
// chip selects. Pin-level monitors rebuild read words and check a scoreboard.
module tb_spi_memory_burst;
    logic clk = 1'b0, reset = 1'b1;
    logic sclk = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1;
    int   checks = 0, failures = 0;
    logic [15:0] exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    spi_memory_burst_if bus_a();
    spi_memory_burst_if bus_b();
    assign bus_a.sclk_pin = sclk;
    assign bus_a.cs_pin   = cs_a;
    assign bus_a.mosi_pin = mosi;
    assign bus_b.sclk_pin = sclk;
    assign bus_b.cs_pin   = cs_b;
    assign bus_b.mosi_pin = mosi;

    spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .spi(bus_a.slave));
    spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset(reset), .spi(bus_b.slave));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low(input bit b);
        @(negedge clk);
        if (b) cs_b = 1'b0; else cs_a = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        cs_a = 1'b1;
        cs_b = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // One full frame; for reads the expected words go onto the scoreboard.
    task automatic xfer(input bit b, input int addr, input bit rd,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input int n);
        int aw, dw;
        logic [15:0] w;
        aw = b ? 4 : 7;
        dw = b ? 16 : 8;
        cs_low(b);
        bits(addr, aw);
        bits({31'd0, rd}, 1);
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            if (rd) begin
                if (b) exp_b.push_back(w); else exp_a.push_back(w);
                bits(0, dw);
            end else begin
                bits({16'd0, w}, dw);
            end
        end
        cs_high();
    endtask

    // Monitor A: master-side view, samples MISO on SCLK rise of read data bits.
    int ma_cnt = 0, ma_nb = 0;
    bit ma_rd = 0, ma_oe = 1;
    logic [15:0] ma_w = '0;
    always @(posedge sclk or posedge cs_a) begin
        if (cs_a) begin
            ma_cnt = 0; ma_nb = 0; ma_rd = 0; ma_oe = 1; ma_w = '0;
        end else begin
            if (ma_cnt == 7) ma_rd = mosi;
            else if (ma_cnt > 7 && ma_rd) begin
                ma_w  = {ma_w[14:0], bus_a.miso_pin};
                ma_oe = ma_oe & bus_a.miso_oe;
                ma_nb++;
                if (ma_nb == 8) begin
                    if (exp_a.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL a_unexpected_word got=%h exp=none", ma_w);
                    end else begin
                        check("a_read_word", {16'd0, ma_w}, {16'd0, exp_a.pop_front()});
                        check("a_miso_oe_data", {31'd0, ma_oe}, 32'd1);
                    end
                    ma_nb = 0; ma_w = '0; ma_oe = 1;
                end
            end
            ma_cnt++;
        end
    end

    // Monitor B: same for the 4-bit address / 16-bit data instance.
    int mb_cnt = 0, mb_nb = 0;
    bit mb_rd = 0, mb_oe = 1;
    logic [15:0] mb_w = '0;
    always @(posedge sclk or posedge cs_b) begin
        if (cs_b) begin
            mb_cnt = 0; mb_nb = 0; mb_rd = 0; mb_oe = 1; mb_w = '0;
        end else begin
            if (mb_cnt == 4) mb_rd = mosi;
            else if (mb_cnt > 4 && mb_rd) begin
                mb_w  = {mb_w[14:0], bus_b.miso_pin};
                mb_oe = mb_oe & bus_b.miso_oe;
                mb_nb++;
                if (mb_nb == 16) begin
                    if (exp_b.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_unexpected_word got=%h exp=none", mb_w);
                    end else begin
                        check("b_read_word", {16'd0, mb_w}, {16'd0, exp_b.pop_front()});
                        check("b_miso_oe_data", {31'd0, mb_oe}, 32'd1);
                    end
                    mb_nb = 0; mb_w = '0; mb_oe = 1;
                end
            end
            mb_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic oe_seen;
        repeat (5) @(negedge clk);
        check("reset_miso_a", {31'd0, bus_a.miso_pin}, 32'd0);
        check("reset_oe_a", {31'd0, bus_a.miso_oe}, 32'd0);
        check("reset_leds_a", {28'd0, bus_a.leds}, 32'd0);
        check("reset_leds_b", {28'd0, bus_b.leds}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Single write then read
        xfer(0, 'h55, 0, 16'h0092, 0, 0, 1);
        check("leds_after_92", {28'd0, bus_a.leds}, 32'h2);
        xfer(0, 'h55, 1, 16'h0092, 0, 0, 1);

        // Burst write across the top of memory, then read back
        xfer(0, 'h7E, 0, 16'h00A1, 16'h00B2, 16'h00C3, 3);
        check("leds_after_burst", {28'd0, bus_a.leds}, 32'h3);
        xfer(0, 'h7E, 1, 16'h00A1, 16'h00B2, 16'h00C3, 3);
        xfer(0, 'h00, 1, 16'h00C3, 0, 0, 1);

        // Aborted write leaves memory and LEDs alone
        xfer(0, 'h10, 0, 16'h005A, 0, 0, 1);
        check("leds_after_5a", {28'd0, bus_a.leds}, 32'hA);
        cs_low(0);
        bits('h10, 7);
        bits(0, 1);
        bits('hF, 4);
        cs_high();
        check("leds_after_abort", {28'd0, bus_a.leds}, 32'hA);
        xfer(0, 'h10, 1, 16'h005A, 0, 0, 1);

        // SCLK/MOSI activity with CS high
        oe_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mosi = i[0];
            half();
            sclk = 1'b1;
            oe_seen = oe_seen | bus_a.miso_oe | bus_b.miso_oe;
            half();
            sclk = 1'b0;
            oe_seen = oe_seen | bus_a.miso_oe | bus_b.miso_oe;
        end
        mosi = 1'b0;
        check("idle_oe", {31'd0, oe_seen}, 32'd0);
        check("idle_leds", {28'd0, bus_a.leds}, 32'hA);
        xfer(0, 'h55, 1, 16'h0092, 0, 0, 1);
        xfer(0, 'h10, 1, 16'h005A, 0, 0, 1);

        // Reset in the middle of a read data phase
        cs_low(0);
        bits('h55, 7);
        bits(1, 1);
        bits(0, 3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_miso", {31'd0, bus_a.miso_pin}, 32'd0);
        check("rst_mid_oe", {31'd0, bus_a.miso_oe}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bits(0, 4);
        check("rst_idle_oe", {31'd0, bus_a.miso_oe}, 32'd0);
        check("rst_idle_miso", {31'd0, bus_a.miso_pin}, 32'd0);
        cs_high();
        check("rst_leds", {28'd0, bus_a.leds}, 32'd0);
        xfer(0, 'h55, 1, 16'h0092, 0, 0, 1);

        // Wide-data / narrow-address instance
        xfer(1, 'h0, 0, 16'h1234, 0, 0, 1);
        xfer(1, 'hF, 0, 16'hBEEF, 0, 0, 1);
        check("b_leds", {28'd0, bus_b.leds}, 32'hF);
        xfer(1, 'hF, 1, 16'hBEEF, 0, 0, 1);
        xfer(1, 'hF, 1, 16'hBEEF, 16'h1234, 0, 2);

        repeat (20) @(negedge clk);
        check("a_queue_drained", exp_a.size(), 32'd0);
        check("b_queue_drained", exp_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
